sqrt_range_reconstruction: RTL and testbench

- Inverse of the sqrt range-reduction stage.
- Takes the square root of the reduced mantissa (from the sqrt core) plus the reduction shift and LZD code produced on the forward side.
- Rescales the root by 2^(±k) to return sqrt of the original Q6.25 operand.
- Two-stage valid/ready pipeline between the sqrt core and the result consumer.

---
 rtl/sqrt_range_reconstruction.sv | 105 ++++++++++
 tb/tb_sqrt_range_reconstruction.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sqrt_range_reconstruction.sv
// Sqrt range reconstruction: rescales the reduced-mantissa root by 2^(+/-k)
// back to the Q6.25 domain through a two-stage valid/ready pipeline.
module sqrt_range_reconstruction (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iValid,
    output logic        oReady,
    input  logic [25:0] iY_f,
    input  logic [5:0]  iExp_f,
    input  logic [5:0]  iExp_f1,
    output logic        oValid,
    input  logic        iReady,
    output logic [30:0] oSqrt,
    output logic        oOvf
);

    logic        v1;
    logic        v2;
    logic [25:0] y1;
    logic        dir1;
    logic [5:0]  k1;

    logic        adv1;
    logic        adv2;

    logic        s_dir;
    logic [5:0]  s_k;

    logic [63:0] l_wide;
    logic        l_ovf;
    logic [25:0] r_sh;
    logic        r_rnd;
    logic [30:0] r_res;
    logic [30:0] n_sqrt;
    logic        n_ovf;

    assign adv2   = ~v2 | iReady;
    assign adv1   = ~v1 | adv2;
    assign oReady = adv1;
    assign oValid = v2;

    // Shift direction and magnitude from the forward LZD code; an odd e on
    // the left side means the forward stage halved once more, so round up.
    always_comb begin
        s_dir = 1'b0;
        s_k   = 6'd0;
        if (iExp_f1 <= 6'd5) begin
            s_dir = 1'b0;
            s_k   = 6'(({1'b0, iExp_f} + 7'd1) >> 1);
        end else if (iExp_f1 >= 6'd7) begin
            s_dir = 1'b1;
            s_k   = {1'b0, iExp_f[5:1]};
        end
    end

    // Rescale the root: left shifts saturate, right shifts round half-up.
    always_comb begin
        l_wide = {38'd0, y1} << k1;
        l_ovf  = |l_wide[63:31];
        r_sh   = y1 >> k1;
        r_rnd  = |(y1 & (26'd1 << (k1 - 6'd1)));
        r_res  = 31'(r_sh) + 31'(r_rnd);
        n_sqrt = l_wide[30:0];
        n_ovf  = 1'b0;
        if (dir1) begin
            n_sqrt = r_res;
        end else if (l_ovf) begin
            n_sqrt = 31'h7FFFFFFF;
            n_ovf  = 1'b1;
        end
    end

    // Stage 1: capture the root and the derived shift when it can advance.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            v1   <= 1'b0;
            y1   <= 26'd0;
            dir1 <= 1'b0;
            k1   <= 6'd0;
        end else if (adv1) begin
            v1 <= iValid;
            if (iValid) begin
                y1   <= iY_f;
                dir1 <= s_dir;
                k1   <= s_k;
            end
        end
    end

    // Stage 2: register the rescaled result; holds while stalled.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            v2    <= 1'b0;
            oSqrt <= 31'd0;
            oOvf  <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                oSqrt <= n_sqrt;
                oOvf  <= n_ovf;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_range_reconstruction.sv
// Directed bench for sqrt_range_reconstruction: shift cases, saturation,
// backpressure and asynchronous reset with hand-computed results.
module tb_sqrt_range_reconstruction;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic        oReady;
    logic [25:0] iY_f;
    logic [5:0]  iExp_f;
    logic [5:0]  iExp_f1;
    logic        oValid;
    logic        iReady;
    logic [30:0] oSqrt;
    logic        oOvf;

    int tests = 0;
    int fails = 0;

    sqrt_range_reconstruction dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iValid  (iValid),
        .oReady  (oReady),
        .iY_f    (iY_f),
        .iExp_f  (iExp_f),
        .iExp_f1 (iExp_f1),
        .oValid  (oValid),
        .iReady  (iReady),
        .oSqrt   (oSqrt),
        .oOvf    (oOvf)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input logic [25:0] y, input logic [5:0] e,
                         input logic [5:0] c);
        iValid  = 1'b1;
        iY_f    = y;
        iExp_f  = e;
        iExp_f1 = c;
    endtask

    // One transfer with iReady=1: accept, check the 2-cycle latency, result.
    task automatic send_one(input string tag, input logic [25:0] y,
                            input logic [5:0] e, input logic [5:0] c,
                            input logic [30:0] es, input logic eo);
        drive(y, e, c);
        chk({tag, "_rdy"}, {31'd0, oReady}, 32'd1);
        tick();
        iValid = 1'b0;
        chk({tag, "_v0"}, {31'd0, oValid}, 32'd0);
        tick();
        chk({tag, "_v1"}, {31'd0, oValid}, 32'd1);
        chk({tag, "_sq"}, {1'b0, oSqrt}, {1'b0, es});
        chk({tag, "_ovf"}, {31'd0, oOvf}, {31'd0, eo});
    endtask

    initial begin
        iRst    = 1'b1;
        iValid  = 1'b0;
        iY_f    = 26'd0;
        iExp_f  = 6'd0;
        iExp_f1 = 6'd6;
        iReady  = 1'b1;
        #12;
        chk("rst_valid", {31'd0, oValid}, 32'd0);
        chk("rst_sqrt", {1'b0, oSqrt}, 32'd0);
        chk("rst_ovf", {31'd0, oOvf}, 32'd0);
        @(negedge iClk);
        iRst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, oReady}, 32'd1);

        send_one("pass", 26'h2000000, 6'd9, 6'd6, 31'h2000000, 1'b0);
        send_one("left_e2", 26'h2000000, 6'd2, 6'd3, 31'h4000000, 1'b0);
        send_one("left_e3", 26'h2000000, 6'd3, 6'd3, 31'h8000000, 1'b0);
        send_one("right_e4", 26'h2000000, 6'd4, 6'd8, 31'h0800000, 1'b0);
        send_one("right_rnd", 26'h0000003, 6'd3, 6'd8, 31'h0000002, 1'b0);
        send_one("right_rnd2", 26'h0000007, 6'd5, 6'd9, 31'h0000002, 1'b0);
        send_one("right_nornd", 26'h0000005, 6'd4, 6'd9, 31'h0000001, 1'b0);
        send_one("sat", 26'h2000000, 6'd11, 6'd0, 31'h7FFFFFFF, 1'b1);
        send_one("after_sat", 26'h1000000, 6'd0, 6'd0, 31'h1000000, 1'b0);
        send_one("left_max", 26'h2000000, 6'd9, 6'd0, 31'h40000000, 1'b0);
        send_one("left_k32", 26'h0000001, 6'd63, 6'd0, 31'h7FFFFFFF, 1'b1);
        send_one("zero_k32", 26'h0000000, 6'd63, 6'd0, 31'h0, 1'b0);
        send_one("right_k26", 26'h2000000, 6'd52, 6'd7, 31'h1, 1'b0);
        send_one("right_k27", 26'h3FFFFFF, 6'd54, 6'd7, 31'h0, 1'b0);
        send_one("zero_right", 26'h0000000, 6'd5, 6'd9, 31'h0, 1'b0);

        // Backpressure: five pass-through values with iReady low for 4 edges.
        tick();
        iReady = 1'b0;
        drive(26'h101, 6'd0, 6'd6);
        chk("bp_rdy0", {31'd0, oReady}, 32'd1);
        tick();
        drive(26'h102, 6'd0, 6'd6);
        chk("bp_rdy1", {31'd0, oReady}, 32'd1);
        chk("bp_v1", {31'd0, oValid}, 32'd0);
        tick();
        drive(26'h103, 6'd0, 6'd6);
        chk("bp_rdy2", {31'd0, oReady}, 32'd0);
        chk("bp_v2", {31'd0, oValid}, 32'd1);
        chk("bp_hold2", {1'b0, oSqrt}, 32'h101);
        tick();
        chk("bp_rdy3", {31'd0, oReady}, 32'd0);
        chk("bp_hold3", {1'b0, oSqrt}, 32'h101);
        tick();
        chk("bp_v4", {31'd0, oValid}, 32'd1);
        chk("bp_hold4", {1'b0, oSqrt}, 32'h101);
        iReady = 1'b1;
        #1;
        chk("bp_rdy_comb", {31'd0, oReady}, 32'd1);
        tick();
        drive(26'h104, 6'd0, 6'd6);
        chk("bp_out2", {1'b0, oSqrt}, 32'h102);
        tick();
        drive(26'h105, 6'd0, 6'd6);
        chk("bp_out3", {1'b0, oSqrt}, 32'h103);
        tick();
        iValid = 1'b0;
        chk("bp_out4", {1'b0, oSqrt}, 32'h104);
        tick();
        chk("bp_out5", {1'b0, oSqrt}, 32'h105);
        chk("bp_v5", {31'd0, oValid}, 32'd1);
        tick();
        chk("bp_empty", {31'd0, oValid}, 32'd0);

        // Async reset with both stages occupied, asserted between edges.
        drive(26'h2000000, 6'd11, 6'd0);
        tick();
        tick();
        chk("ar_pre_v", {31'd0, oValid}, 32'd1);
        chk("ar_pre_ovf", {31'd0, oOvf}, 32'd1);
        #2;
        iRst = 1'b1;
        #1;
        chk("ar_valid", {31'd0, oValid}, 32'd0);
        chk("ar_sqrt", {1'b0, oSqrt}, 32'd0);
        chk("ar_ovf", {31'd0, oOvf}, 32'd0);
        iValid = 1'b0;
        @(negedge iClk);
        iRst = 1'b0;
        #1;
        send_one("ar_post", 26'h2000000, 6'd0, 6'd6, 31'h2000000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
